// File: rtl/heap_port_arbiter_pkg.sv
// Shared types for the heap port arbiter: default widths, request record, lock FSM states.
// Also holds the small wrap-around increment used for the round-robin pointer.
package heap_port_arbiter_pkg;

  localparam int NRequestersDefault = 3;
  localparam int HeapAddressWidth   = 12;
  localparam int HeapDataWidth      = 12;

  typedef logic [$clog2(NRequestersDefault)-1:0] req_id_t;

  typedef struct packed {
    logic                        write;
    logic                        lock;
    logic [HeapAddressWidth-1:0] address;
    logic [HeapDataWidth-1:0]    data;
  } heap_req_t;

  typedef enum logic {
    LOCK_UNLOCKED = 1'b0,
    LOCK_LOCKED   = 1'b1
  } lock_state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/heap_port_arbiter_if.sv
// Requester-side bus of the heap port arbiter: per-requester request handshake plus routed responses.
// Responses carry no ready; requesters must always accept resp_valid.
interface heap_port_arbiter_if #(
  parameter int NRequesters        = heap_port_arbiter_pkg::NRequestersDefault,
  parameter int AddressWidth       = heap_port_arbiter_pkg::HeapAddressWidth,
  parameter int MemoryElementWidth = heap_port_arbiter_pkg::HeapDataWidth
);
  import heap_port_arbiter_pkg::*;

  logic [NRequesters-1:0]                    req_valid;
  logic [NRequesters-1:0]                    req_write;
  logic [NRequesters-1:0]                    req_lock;
  logic [NRequesters*AddressWidth-1:0]       req_address;
  logic [NRequesters*MemoryElementWidth-1:0] req_in;
  logic [NRequesters-1:0]                    req_ready;
  logic [NRequesters-1:0]                    resp_valid;
  logic [MemoryElementWidth-1:0]             resp_data;

  modport master (
    output req_valid, req_write, req_lock, req_address, req_in,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_lock, req_address, req_in,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/heap_port_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set bit of valid at or above ptr, wrapping.
// Zero latency; no state, so it can be shared with other arbiters (e.g. the free-list).
module rr_priority_picker #(
  parameter int NRequesters = heap_port_arbiter_pkg::NRequestersDefault,
  parameter int IdW         = (NRequesters > 1) ? $clog2(NRequesters) : 1
) (
  input  logic [NRequesters-1:0] valid,
  input  logic [IdW-1:0]         ptr,
  output logic [NRequesters-1:0] grant_oh,
  output logic [IdW-1:0]         grant_idx,
  output logic                   grant_any
);
  import heap_port_arbiter_pkg::*;

  always_comb begin
    int idx;
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < NRequesters; k++) begin
      idx = (int'(ptr) + k) % NRequesters;
      if (!grant_any && valid[idx]) begin
        grant_any     = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/heap_port_arbiter.sv
// Shares single-port heapMemory among requesters: round-robin grant, optional lock for RMW sequences.
// Accept edge E0 -> resp_valid in the cycle after E0+1, one accept per cycle; responses cannot stall.
module heap_port_arbiter
  import heap_port_arbiter_pkg::*;
#(
  parameter int NRequesters        = NRequestersDefault,
  parameter int AddressWidth       = HeapAddressWidth,
  parameter int MemoryElementWidth = HeapDataWidth
) (
  input  logic                          clock,
  input  logic                          reset,
  heap_port_arbiter_if.slave            bus,
  output logic                          mem_write,
  output logic [AddressWidth-1:0]       mem_address,
  output logic [MemoryElementWidth-1:0] mem_in,
  input  logic [MemoryElementWidth-1:0] mem_out
);

  localparam int IdW = (NRequesters > 1) ? $clog2(NRequesters) : 1;

  lock_state_t                   state_q, state_d;
  logic [IdW-1:0]                lock_owner_q, lock_owner_d;
  logic [IdW-1:0]                ptr_q, ptr_d;
  logic                          issue_vld_q, issue_vld_d;
  logic [IdW-1:0]                issue_owner_q, issue_owner_d;
  logic                          resp_vld_q, resp_vld_d;
  logic [IdW-1:0]                resp_owner_q, resp_owner_d;
  logic                          mem_write_q, mem_write_d;
  logic [AddressWidth-1:0]       mem_address_q, mem_address_d;
  logic [MemoryElementWidth-1:0] mem_in_q, mem_in_d;

  logic [NRequesters-1:0] eligible;
  logic [NRequesters-1:0] lock_mask;
  logic [NRequesters-1:0] grant_oh;
  logic [IdW-1:0]         grant_idx;
  logic                   grant_any;
  logic                   accept;
  heap_req_t              sel_req;
  logic [NRequesters-1:0] resp_oh;

  // A held lock hides every other requester, even while the owner is idle.
  always_comb begin
    lock_mask            = '0;
    lock_mask[lock_owner_q] = 1'b1;
    eligible             = bus.req_valid;
    if (state_q == LOCK_LOCKED) begin
      eligible = bus.req_valid & lock_mask;
    end
  end

  rr_priority_picker #(
    .NRequesters(NRequesters),
    .IdW        (IdW)
  ) u_picker (
    .valid    (eligible),
    .ptr      (ptr_q),
    .grant_oh (grant_oh),
    .grant_idx(grant_idx),
    .grant_any(grant_any)
  );

  assign accept        = grant_any && !reset;
  assign bus.req_ready = reset ? '0 : grant_oh;

  always_comb begin
    sel_req         = '0;
    sel_req.write   = bus.req_write[grant_idx];
    sel_req.lock    = bus.req_lock[grant_idx];
    sel_req.address = bus.req_address[int'(grant_idx)*AddressWidth +: AddressWidth];
    sel_req.data    = bus.req_in[int'(grant_idx)*MemoryElementWidth +: MemoryElementWidth];
  end

  always_comb begin
    state_d       = state_q;
    lock_owner_d  = lock_owner_q;
    ptr_d         = ptr_q;
    issue_vld_d   = accept;
    issue_owner_d = grant_idx;
    resp_vld_d    = issue_vld_q;
    resp_owner_d  = issue_owner_q;
    mem_write_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_in_d      = mem_in_q;

    // While locked only the owner is accepted, so this keeps the pointer at owner+1.
    if (accept) begin
      ptr_d         = IdW'(wrap_inc(int'(grant_idx), NRequesters));
      mem_write_d   = sel_req.write;
      mem_address_d = sel_req.address;
      mem_in_d      = sel_req.data;
    end

    case (state_q)
      LOCK_UNLOCKED: begin
        if (accept && sel_req.lock) begin
          state_d      = LOCK_LOCKED;
          lock_owner_d = grant_idx;
        end
      end
      LOCK_LOCKED: begin
        if (accept && !sel_req.lock) begin
          state_d = LOCK_UNLOCKED;
        end
      end
      default: state_d = LOCK_UNLOCKED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= LOCK_UNLOCKED;
      lock_owner_q  <= '0;
      ptr_q         <= '0;
      issue_vld_q   <= 1'b0;
      issue_owner_q <= '0;
      resp_vld_q    <= 1'b0;
      resp_owner_q  <= '0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_in_q      <= '0;
    end else begin
      state_q       <= state_d;
      lock_owner_q  <= lock_owner_d;
      ptr_q         <= ptr_d;
      issue_vld_q   <= issue_vld_d;
      issue_owner_q <= issue_owner_d;
      resp_vld_q    <= resp_vld_d;
      resp_owner_q  <= resp_owner_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_in_q      <= mem_in_d;
    end
  end

  always_comb begin
    resp_oh = '0;
    if (resp_vld_q && !reset) begin
      resp_oh[resp_owner_q] = 1'b1;
    end
  end

  assign bus.resp_valid = resp_oh;
  assign bus.resp_data  = mem_out;
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_in         = mem_in_q;

endmodule

// File: tb/tb_heap_port_arbiter.sv
// Bench for heap_port_arbiter: heapMemory model, grant/response scoreboard, vector table and corner sequences.
module tb_heap_port_arbiter;
  import heap_port_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 12;
  localparam int DW = 12;

  logic          clock;
  logic          reset;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_in;
  logic [DW-1:0] mem_out;

  heap_port_arbiter_if #(.NRequesters(N), .AddressWidth(AW), .MemoryElementWidth(DW)) bus ();

  heap_port_arbiter #(.NRequesters(N), .AddressWidth(AW), .MemoryElementWidth(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_in     (mem_in),
    .mem_out    (mem_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // heapMemory: synchronous, write-through output on writes
  logic [DW-1:0] heap [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (mem_write) heap[mem_address] <= mem_in;
    mem_out <= mem_write ? mem_in : heap[mem_address];
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int owner;
    int data;
    int due;
  } exp_t;
  exp_t sbq[$];

  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            last_resp [N];
  int            mptr    = 0;
  logic          mlocked = 1'b0;
  int            mowner  = 0;

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v);
    logic [N-1:0] g;
    logic [N-1:0] m;
    int           i;
    g = '0;
    m = v;
    if (mlocked) begin
      m = '0;
      m[mowner] = v[mowner];
    end
    for (int k = 0; k < N; k++) begin
      i = (mptr + k) % N;
      if (m[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic int first_bit(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Monitor: responses popped against the scoreboard, grants checked against the model, accepts pushed.
  always @(negedge clock) begin
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  acc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    exp_t          e;
    int            o;
    if (reset) begin
      sbq.delete();
      mptr    = 0;
      mlocked = 1'b0;
      mowner  = 0;
      chk("rst_resp_suppressed", int'(bus.resp_valid), 0);
    end else begin
      chk("resp_onehot", int'($countones(bus.resp_valid) <= 1), 1);
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        e = sbq.pop_front();
        chk("missing_resp_cycle", cyc, e.due);
      end
      if (bus.resp_valid != '0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", int'(bus.resp_valid), 0);
        end else begin
          e = sbq.pop_front();
          o = first_bit(bus.resp_valid);
          chk("resp_owner", o, e.owner);
          chk("resp_data", int'(bus.resp_data), e.data);
          chk("resp_cycle", cyc, e.due);
          if (o >= 0) last_resp[o] = int'(bus.resp_data);
        end
      end
      exp_rdy = model_grant(bus.req_valid);
      chk("ready_model", int'(bus.req_ready), int'(exp_rdy));
      acc = bus.req_valid & bus.req_ready;
      for (int g = 0; g < N; g++) begin
        if (acc[g]) begin
          a = bus.req_address[g*AW +: AW];
          d = bus.req_in[g*DW +: DW];
          if (bus.req_write[g]) begin
            shadow[a] = d;
            e.data = int'(d);
          end else begin
            e.data = int'(shadow[a]);
          end
          e.owner = g;
          e.due   = cyc + 2;
          sbq.push_back(e);
          mptr = (g + 1) % N;
          if (bus.req_lock[g]) begin
            mlocked = 1'b1;
            mowner  = g;
          end else begin
            mlocked = 1'b0;
          end
        end
      end
    end
  end

  logic [AW-1:0] addr [N];
  logic [DW-1:0] wdat [N];

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] w, input logic [N-1:0] l);
    @(posedge clock);
    #1;
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_lock  = l;
    for (int i = 0; i < N; i++) begin
      bus.req_address[i*AW +: AW] = addr[i];
      bus.req_in[i*DW +: DW]      = wdat[i];
    end
    @(negedge clock);
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1;
    reset         = 1'b1;
    bus.req_valid = '1;
    bus.req_write = '0;
    bus.req_lock  = '0;
    @(negedge clock);
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_resp_valid", int'(bus.resp_valid), 0);
    @(posedge clock);
    @(negedge clock);
    chk("rst_mem_write", int'(mem_write), 0);
    chk("rst_mem_address", int'(mem_address), 0);
    chk("rst_mem_in", int'(mem_in), 0);
    chk("rst_ready_held", int'(bus.req_ready), 0);
    @(posedge clock);
    #1;
    reset         = 1'b0;
    bus.req_valid = '0;
    @(negedge clock);
  endtask

  typedef struct {
    logic [N-1:0]  v;
    logic [N-1:0]  w;
    logic [N-1:0]  l;
    logic [AW-1:0] a1;
    logic [N-1:0]  exp_rdy;
  } row_t;
  row_t tbl [13];

  initial begin
    logic [N-1:0] rv, rw, rl;

    // rotation over three readers, then req1 lock / idle / unlock with 0 and 2 pending
    tbl[0]  = '{3'b111, 3'b000, 3'b000, 12'd11, 3'b001};
    tbl[1]  = '{3'b111, 3'b000, 3'b000, 12'd11, 3'b010};
    tbl[2]  = '{3'b111, 3'b000, 3'b000, 12'd11, 3'b100};
    tbl[3]  = '{3'b111, 3'b000, 3'b000, 12'd11, 3'b001};
    tbl[4]  = '{3'b111, 3'b000, 3'b000, 12'd11, 3'b010};
    tbl[5]  = '{3'b111, 3'b000, 3'b000, 12'd11, 3'b100};
    tbl[6]  = '{3'b001, 3'b000, 3'b000, 12'd11, 3'b001};
    tbl[7]  = '{3'b111, 3'b000, 3'b010, 12'd7,  3'b010};
    tbl[8]  = '{3'b101, 3'b000, 3'b000, 12'd7,  3'b000};
    tbl[9]  = '{3'b101, 3'b000, 3'b000, 12'd7,  3'b000};
    tbl[10] = '{3'b111, 3'b010, 3'b000, 12'd7,  3'b010};
    tbl[11] = '{3'b101, 3'b000, 3'b000, 12'd7,  3'b100};
    tbl[12] = '{3'b101, 3'b000, 3'b000, 12'd7,  3'b001};

    for (int i = 0; i < (1 << AW); i++) begin
      heap[i]   = '0;
      shadow[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      addr[i]      = '0;
      wdat[i]      = '0;
      last_resp[i] = -1;
    end
    reset           = 1'b1;
    bus.req_valid   = '0;
    bus.req_write   = '0;
    bus.req_lock    = '0;
    bus.req_address = '0;
    bus.req_in      = '0;

    apply_reset();

    // write then read back through req0
    addr[0] = 12'd3;
    wdat[0] = 12'h05A;
    step(3'b001, 3'b001, 3'b000);
    chk("t1_write_ready", int'(bus.req_ready), 1);
    step(3'b001, 3'b000, 3'b000);
    chk("t1_read_ready", int'(bus.req_ready), 1);
    repeat (3) step(3'b000, 3'b000, 3'b000);
    chk("t1_read_data", last_resp[0], 12'h05A);

    // preload the rotation addresses
    addr[0] = 12'd10; wdat[0] = 12'h0A0;
    addr[1] = 12'd11; wdat[1] = 12'h0B1;
    addr[2] = 12'd12; wdat[2] = 12'h0C2;
    step(3'b001, 3'b001, 3'b000);
    step(3'b010, 3'b010, 3'b000);
    step(3'b100, 3'b100, 3'b000);
    repeat (3) step(3'b000, 3'b000, 3'b000);

    apply_reset();
    wdat[1] = 12'h777;
    for (int r = 0; r < 13; r++) begin
      addr[1] = tbl[r].a1;
      step(tbl[r].v, tbl[r].w, tbl[r].l);
      chk($sformatf("tbl_ready_row%0d", r), int'(bus.req_ready), int'(tbl[r].exp_rdy));
    end
    repeat (3) step(3'b000, 3'b000, 3'b000);
    chk("tbl_last_req0", last_resp[0], 12'h0A0);
    chk("tbl_last_req1", last_resp[1], 12'h777);
    chk("tbl_last_req2", last_resp[2], 12'h0C2);

    // back-to-back write then read of the same address from different requesters
    apply_reset();
    addr[0] = 12'd5; wdat[0] = 12'h123;
    addr[1] = 12'd5;
    step(3'b001, 3'b001, 3'b000);
    chk("t4_write_ready", int'(bus.req_ready), 1);
    step(3'b010, 3'b000, 3'b000);
    chk("t4_read_ready", int'(bus.req_ready), 2);
    repeat (3) step(3'b000, 3'b000, 3'b000);
    chk("t4_read_data", last_resp[1], 12'h123);

    // reset right after a locking write: response dropped, pointer and lock cleared
    addr[1] = 12'd9; wdat[1] = 12'h3C3;
    step(3'b010, 3'b010, 3'b010);
    chk("t5_lock_ready", int'(bus.req_ready), 2);
    apply_reset();
    step(3'b111, 3'b000, 3'b000);
    chk("t5_first_grant", int'(bus.req_ready), 1);
    step(3'b111, 3'b000, 3'b000);
    chk("t5_second_grant", int'(bus.req_ready), 2);
    repeat (3) step(3'b000, 3'b000, 3'b000);

    // random traffic against the monitor's model
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        addr[i] = AW'($urandom_range(15));
        wdat[i] = DW'($urandom_range((1 << DW) - 1));
        rl[i]   = ($urandom_range(7) == 0);
      end
      rv = N'($urandom_range((1 << N) - 1));
      rw = N'($urandom_range((1 << N) - 1));
      step(rv, rw, rl);
    end
    repeat (4) step(3'b000, 3'b000, 3'b000);
    chk("queue_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
